sipo_frame_rx: RTL and testbench

//  Receive end of the single-bit serial link driven by the SISO shift chain.

---
 rtl/sipo_frame_rx_if.sv | 24 ++
 rtl/sipo_frame_rx.sv | 122 ++++++++++++
 tb/tb_sipo_frame_rx.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_frame_rx_if.sv
// Link-side bundle of the serial frame receiver: serial input, output word handshake and status.
// The slave modport is the receiver's view and the master modport is the driver/consumer view.
interface sipo_frame_rx_if #(
    parameter int DATA_W = 8
);
    logic              si;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              frame_err;
    logic              par_err;
    logic              overrun;
    logic              ovr_clr;

    modport slave (
        input  si, data_ready, ovr_clr,
        output data_out, data_valid, frame_err, par_err, overrun
    );

    modport master (
        output si, data_ready, ovr_clr,
        input  data_out, data_valid, frame_err, par_err, overrun
    );
endinterface

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start(1), DATA_W data bits LSB-first, optional even parity, stop(0).
// Define SIPO_RX_PARITY_EN to expect a parity bit; the default build has no parity stage.
module sipo_frame_rx #(
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    sipo_frame_rx_if.slave bus
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

`ifdef SIPO_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  shreg;
    logic [DATA_W-1:0]  data_q;
    logic               valid_q;
    logic               frame_err_q;
    logic               overrun_q;
    logic               par_fail;
    logic               pop;
    logic               commit;
    logic               last_bit;

`ifdef SIPO_RX_PARITY_EN
    logic par_bit;
    logic par_err_q;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        par_fail = 1'b0;
`ifdef SIPO_RX_PARITY_EN
        par_fail = (^shreg) ^ par_bit;
`endif
        pop      = valid_q & bus.data_ready;
        commit   = (state == STOP) & ~bus.si & ~par_fail;
        last_bit = (cnt == CNT_W'(DATA_W - 1));
    end

    // NOTE: all state below is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            par_bit     <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.si) state <= DATA;
                end
                DATA: begin
                    shreg[cnt] <= bus.si;
                    if (last_bit) begin
`ifdef SIPO_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef SIPO_RX_PARITY_EN
                PARITY: begin
                    par_bit <= bus.si;
                    state   <= STOP;
                end
`endif
                STOP: begin
                    state       <= IDLE;
                    frame_err_q <= bus.si;
`ifdef SIPO_RX_PARITY_EN
                    par_err_q   <= par_fail;
`endif
                end
                default: state <= IDLE;
            endcase

            // A pop frees the buffer on the same edge, so a simultaneous commit still lands.
            if (commit && (!valid_q || pop)) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
            end else if (pop) begin
                valid_q <= 1'b0;
            end

            if (commit && valid_q && !pop) overrun_q <= 1'b1;
            else if (bus.ovr_clr)          overrun_q <= 1'b0;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
`ifdef SIPO_RX_PARITY_EN
    assign bus.par_err    = par_err_q;
`else
    assign bus.par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx: scenario tasks drive frames, a handshake monitor checks words
// against a scoreboard queue of expected values.
module tb_sipo_frame_rx;

    localparam int DATA_W = 8;
`ifdef SIPO_RX_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 3;
`else
    localparam int FRAME_LEN = DATA_W + 2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic [DATA_W-1:0] sb[$];
    int                pop_cyc[$];

    sipo_frame_rx_if #(.DATA_W(DATA_W)) bus ();

    sipo_frame_rx #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Handshake monitor: a word is transferred on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.data_valid && bus.data_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %h, scoreboard empty", bus.data_out);
            end else begin
                logic [DATA_W-1:0] exp_w;
                exp_w = sb.pop_front();
                if (bus.data_out !== exp_w) begin
                    errors++;
                    $display("FAIL word: got %h, expected %h", bus.data_out, exp_w);
                end
            end
            pop_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_bit(input logic b);
        bus.si = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic stop_bit, input logic par_flip);
        drive_bit(1'b1);
        for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
`ifdef SIPO_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop_bit);
        bus.si = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_bit(1'b0);
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, got, exp_v);
        end
    endtask

    task automatic check_word(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp_v);
        end
    endtask

    task automatic test_reset;
        // Outputs during the power-on reset.
        check_bit("rst_valid", bus.data_valid, 1'b0);
        check_word("rst_data", bus.data_out, '0);
        check_bit("rst_frame_err", bus.frame_err, 1'b0);
        check_bit("rst_par_err", bus.par_err, 1'b0);
        check_bit("rst_overrun", bus.overrun, 1'b0);
        rst_n = 1'b1;
        idle(2);
        // Park a word in the buffer, then reset after 3 data bits of the next frame.
        bus.data_ready = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0);
        check_bit("pre_rst_valid", bus.data_valid, 1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rst_n = 1'b0;
        bus.si = 1'b0;
        #2;
        check_bit("mid_rst_valid", bus.data_valid, 1'b0);
        check_word("mid_rst_data", bus.data_out, '0);
        check_bit("mid_rst_overrun", bus.overrun, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        bus.data_ready = 1'b1;
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0);
        idle(2);
    endtask

    task automatic test_single;
        bus.data_ready = 1'b1;
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0);
        check_bit("single_valid_lat", bus.data_valid, 1'b1);
        check_word("single_data", bus.data_out, 8'hA5);
        idle(1);
        check_bit("single_valid_clr", bus.data_valid, 1'b0);
        check_word("single_data_hold", bus.data_out, 8'hA5);
        idle(2);
    endtask

    task automatic test_back_to_back;
        bus.data_ready = 1'b1;
        pop_cyc.delete();
        sb.push_back(8'h3C);
        sb.push_back(8'hC3);
        send_frame(8'h3C, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0);
        idle(2);
        checks++;
        if (pop_cyc.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d words, expected 2", pop_cyc.size());
        end else begin
            checks++;
            if (pop_cyc[1] - pop_cyc[0] != FRAME_LEN) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d cycles, expected %0d", pop_cyc[1] - pop_cyc[0], FRAME_LEN);
            end
        end
    endtask

    task automatic test_overrun;
        bus.data_ready = 1'b0;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        check_bit("ovr_set", bus.overrun, 1'b1);
        check_word("ovr_data_kept", bus.data_out, 8'h11);
        check_bit("ovr_valid", bus.data_valid, 1'b1);
        idle(1);
        check_bit("ovr_sticky", bus.overrun, 1'b1);
        bus.ovr_clr = 1'b1;
        idle(1);
        bus.ovr_clr = 1'b0;
        check_bit("ovr_clr", bus.overrun, 1'b0);
        bus.data_ready = 1'b1;
        idle(1);
        check_bit("ovr_popped", bus.data_valid, 1'b0);
        check_word("ovr_pop_hold", bus.data_out, 8'h11);
        idle(1);
    endtask

    task automatic test_frame_err;
        bus.data_ready = 1'b1;
        send_frame(8'h55, 1'b1, 1'b0);
        check_bit("ferr_pulse", bus.frame_err, 1'b1);
        check_bit("ferr_no_valid", bus.data_valid, 1'b0);
        idle(1);
        check_bit("ferr_pulse_end", bus.frame_err, 1'b0);
        check_bit("ferr_still_no_valid", bus.data_valid, 1'b0);
        sb.push_back(8'h0F);
        send_frame(8'h0F, 1'b0, 1'b0);
        check_bit("ferr_recover_valid", bus.data_valid, 1'b1);
        idle(2);
    endtask

    task automatic test_parity;
        bus.data_ready = 1'b1;
`ifdef SIPO_RX_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b1);
        check_bit("perr_pulse", bus.par_err, 1'b1);
        check_bit("perr_no_valid", bus.data_valid, 1'b0);
        idle(1);
        check_bit("perr_pulse_end", bus.par_err, 1'b0);
        sb.push_back(8'h07);
        send_frame(8'h07, 1'b0, 1'b0);
        check_bit("perr_good_none", bus.par_err, 1'b0);
        check_word("perr_good_data", bus.data_out, 8'h07);
`else
        sb.push_back(8'h07);
        send_frame(8'h07, 1'b0, 1'b0);
        check_bit("par_err_tied", bus.par_err, 1'b0);
        check_word("nopar_data", bus.data_out, 8'h07);
`endif
        idle(2);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.si         = 1'b0;
        bus.data_ready = 1'b0;
        bus.ovr_clr    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_parity();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d words left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
